// File: rtl/duck_sprite_sched_pkg.sv
// Shared constants, animation state encoding and width helper for the duck sprite scheduler.
package duck_sprite_pkg;

    localparam int N_SLOTS_DEF   = 4;
    localparam int SPR_W_DEF     = 64;
    localparam int SPR_H_DEF     = 64;
    localparam int FRAMES_DEF    = 4;
    localparam int FRAME_DIV_DEF = 8;

    localparam logic [9:0] H_LAST = 10'd639;
    localparam logic [9:0] V_LAST = 10'd479;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } anim_state_t;

    // Keeps index/counter vectors at least one bit wide for degenerate parameter values.
    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/duck_sprite_sched_if.sv
// Pixel-side bundle of the duck sprite scheduler: beam coordinates in, ROM address and status out.
interface duck_sprite_sched_if
    import duck_sprite_pkg::*;
#(
    parameter  int N_SLOTS = N_SLOTS_DEF,
    parameter  int FRAMES  = FRAMES_DEF,
    parameter  int ADDR_W  = 14,
    localparam int SLOT_W  = clog2_min1(N_SLOTS),
    localparam int FW      = clog2_min1(FRAMES)
);

    logic [9:0]        DrawX;
    logic [9:0]        DrawY;
    logic              blank;
    logic [ADDR_W-1:0] rom_address;
    logic              hit;
    logic [SLOT_W-1:0] hit_slot;
    logic [FW-1:0]     frame_idx;
    logic              frame_tick;

    // The video timing side owns the beam; the scheduler answers with ROM address and status.
    modport master (
        output DrawX, DrawY, blank,
        input  rom_address, hit, hit_slot, frame_idx, frame_tick
    );

    modport slave (
        input  DrawX, DrawY, blank,
        output rom_address, hit, hit_slot, frame_idx, frame_tick
    );

endinterface

// File: rtl/duck_sprite_sched_anim.sv
// Animation sequencer: IDLE/RUN/PAUSE FSM, frame divider and restart handling.
// frame_idx only ever moves on a frame_tick cycle so a displayed frame never mixes two animation frames.
module duck_anim_seq
    import duck_sprite_pkg::*;
#(
    parameter  int FRAMES    = FRAMES_DEF,
    parameter  int FRAME_DIV = FRAME_DIV_DEF,
    localparam int FW        = clog2_min1(FRAMES),
    localparam int DW        = clog2_min1(FRAME_DIV)
) (
    input  logic          vga_clk,
    input  logic          reset_n,
    input  logic          frame_tick,
    input  logic          anim_run,
    input  logic          anim_restart,
    output logic [FW-1:0] frame_idx
);

    localparam logic [1:0]    S_IDLE   = IDLE;
    localparam logic [1:0]    S_RUN    = RUN;
    localparam logic [1:0]    S_PAUSE  = PAUSE;
    localparam logic [DW-1:0] DIV_LAST = DW'(FRAME_DIV - 1);

    logic [1:0]    state;
    logic [DW-1:0] divider;
    logic          pending_restart;
    logic          step_now;

    assign step_now = frame_tick && (state == S_RUN) && (divider == DIV_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else if (anim_restart) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (anim_run)  state <= S_RUN;
                S_RUN:   if (!anim_run) state <= S_PAUSE;
                S_PAUSE: if (anim_run)  state <= S_RUN;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            divider <= '0;
        end else if (anim_restart || state == S_IDLE) begin
            divider <= '0;
        end else if (frame_tick && state == S_RUN) begin
            divider <= (divider == DIV_LAST) ? '0 : divider + DW'(1);
        end
    end

    // A restart requested mid-frame is deferred to the next frame_tick; a restart on the tick itself wins over a step.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_idx       <= '0;
            pending_restart <= 1'b0;
        end else begin
            if (frame_tick) begin
                if (anim_restart || pending_restart) frame_idx <= '0;
                else if (step_now)                   frame_idx <= frame_idx + FW'(1);
            end
            if (frame_tick)        pending_restart <= 1'b0;
            else if (anim_restart) pending_restart <= 1'b1;
        end
    end

endmodule

// File: rtl/duck_sprite_sched.sv
// Per-pixel duck sprite slot arbiter and ROM address generator with tear-free slot shadowing.
// Optional build macro DUCK_SPRITE_MIRROR_EN adds slot_flip for per-slot horizontal mirroring.
module duck_sprite_sched
    import duck_sprite_pkg::*;
#(
    parameter  int N_SLOTS   = N_SLOTS_DEF,
    parameter  int SPR_W     = SPR_W_DEF,
    parameter  int SPR_H     = SPR_H_DEF,
    parameter  int FRAMES    = FRAMES_DEF,
    parameter  int FRAME_DIV = FRAME_DIV_DEF,
    localparam int ADDR_W    = $clog2(FRAMES * SPR_W * SPR_H),
    localparam int SLOT_W    = clog2_min1(N_SLOTS),
    localparam int FW        = clog2_min1(FRAMES)
) (
    input  logic                   vga_clk,
    input  logic                   reset_n,
    input  logic [N_SLOTS-1:0]     slot_en,
`ifdef DUCK_SPRITE_MIRROR_EN
    input  logic [N_SLOTS-1:0]     slot_flip,
`endif
    input  logic [10*N_SLOTS-1:0]  slot_x,
    input  logic [10*N_SLOTS-1:0]  slot_y,
    input  logic                   anim_run,
    input  logic                   anim_restart,
    duck_sprite_sched_if.slave     pix
);

    localparam int XW = $clog2(SPR_W);
    localparam int YW = $clog2(SPR_H);
    localparam logic [10:0] SPR_W11 = 11'(SPR_W);
    localparam logic [10:0] SPR_H11 = 11'(SPR_H);
    localparam logic [XW-1:0] COL_LAST = XW'(SPR_W - 1);

    logic [N_SLOTS-1:0] en_s;
    logic [N_SLOTS-1:0] flip_s;
    logic [9:0]         x_s [N_SLOTS];
    logic [9:0]         y_s [N_SLOTS];

    logic [N_SLOTS-1:0] hit_vec;
    logic               win_hit;
    logic [SLOT_W-1:0]  win_slot;
    logic [9:0]         dx;
    logic [9:0]         dy;
    logic [XW-1:0]      col;
    logic [ADDR_W-1:0]  addr_next;

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) pix.frame_tick <= 1'b0;
        else          pix.frame_tick <= (pix.DrawX == H_LAST) && (pix.DrawY == V_LAST);
    end

    // Slot state is sampled only on frame_tick, so game logic may update it at any time without tearing.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            en_s   <= '0;
            flip_s <= '0;
            for (int i = 0; i < N_SLOTS; i++) begin
                x_s[i] <= '0;
                y_s[i] <= '0;
            end
        end else if (pix.frame_tick) begin
            en_s <= slot_en;
`ifdef DUCK_SPRITE_MIRROR_EN
            flip_s <= slot_flip;
`else
            flip_s <= '0;
`endif
            for (int i = 0; i < N_SLOTS; i++) begin
                x_s[i] <= slot_x[10*i +: 10];
                y_s[i] <= slot_y[10*i +: 10];
            end
        end
    end

    // Edge sums are 11 bits wide so a sprite hanging off the right or bottom edge clips instead of wrapping.
    always_comb begin
        for (int i = 0; i < N_SLOTS; i++) begin
            hit_vec[i] = pix.blank && en_s[i]
                      && ({1'b0, pix.DrawX} >= {1'b0, x_s[i]})
                      && ({1'b0, pix.DrawX} <  ({1'b0, x_s[i]} + SPR_W11))
                      && ({1'b0, pix.DrawY} >= {1'b0, y_s[i]})
                      && ({1'b0, pix.DrawY} <  ({1'b0, y_s[i]} + SPR_H11));
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        win_hit  = 1'b0;
        win_slot = '0;
        for (int i = N_SLOTS - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                win_hit  = 1'b1;
                win_slot = SLOT_W'(i);
            end
        end
    end

    // Power-of-two sprite and frame sizes turn frame*W*H + row*W + col into a plain concatenation.
    always_comb begin
        dx        = pix.DrawX - x_s[win_slot];
        dy        = pix.DrawY - y_s[win_slot];
        col       = flip_s[win_slot] ? (COL_LAST - dx[XW-1:0]) : dx[XW-1:0];
        addr_next = {pix.frame_idx, dy[YW-1:0], col};
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            pix.rom_address <= '0;
            pix.hit         <= 1'b0;
            pix.hit_slot    <= '0;
        end else begin
            pix.rom_address <= win_hit ? addr_next : '0;
            pix.hit         <= win_hit;
            pix.hit_slot    <= win_slot;
        end
    end

    duck_anim_seq #(
        .FRAMES    (FRAMES),
        .FRAME_DIV (FRAME_DIV)
    ) u_anim (
        .vga_clk      (vga_clk),
        .reset_n      (reset_n),
        .frame_tick   (pix.frame_tick),
        .anim_run     (anim_run),
        .anim_restart (anim_restart),
        .frame_idx    (pix.frame_idx)
    );

endmodule

// File: tb/tb_duck_sprite_sched.sv
// Directed self-checking bench for duck_sprite_sched; the mirror check runs when DUCK_SPRITE_MIRROR_EN is defined.
module tb_duck_sprite_sched;

    logic        vga_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  slot_en = '0;
    logic [3:0]  slot_flip = '0;
    logic [39:0] slot_x = '0;
    logic [39:0] slot_y = '0;
    logic        anim_run = 1'b0;
    logic        anim_restart = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 vga_clk = ~vga_clk;

    duck_sprite_sched_if #(.N_SLOTS(4), .FRAMES(4), .ADDR_W(14)) pix_if ();

    duck_sprite_sched dut (
        .vga_clk      (vga_clk),
        .reset_n      (reset_n),
        .slot_en      (slot_en),
`ifdef DUCK_SPRITE_MIRROR_EN
        .slot_flip    (slot_flip),
`endif
        .slot_x       (slot_x),
        .slot_y       (slot_y),
        .anim_run     (anim_run),
        .anim_restart (anim_restart),
        .pix          (pix_if)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_tests++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Present one pixel, then sample the registered outputs 1 time unit after the capturing edge.
    task automatic step(input int x, input int y);
        pix_if.DrawX = 10'(x);
        pix_if.DrawY = 10'(y);
        @(posedge vga_clk);
        #1;
    endtask

    task automatic frame();
        step(639, 479);
        step(0, 0);
    endtask

    task automatic set_slot(input int i, input logic en, input int x, input int y);
        slot_en[i]         = en;
        slot_x[10*i +: 10] = 10'(x);
        slot_y[10*i +: 10] = 10'(y);
    endtask

    task automatic check_pix(input string tag, input logic h, input int slot, input int addr);
        check({tag, "_hit"},  32'(pix_if.hit), 32'(h));
        check({tag, "_slot"}, 32'(pix_if.hit_slot), 32'(slot));
        check({tag, "_addr"}, 32'(pix_if.rom_address), 32'(addr));
    endtask

    initial begin
        pix_if.DrawX = '0;
        pix_if.DrawY = '0;
        pix_if.blank = 1'b1;

        repeat (2) @(posedge vga_clk);
        #1;
        check_pix("rst", 1'b0, 0, 0);
        check("rst_tick", 32'(pix_if.frame_tick), 32'd0);
        check("rst_fidx", 32'(pix_if.frame_idx), 32'd0);
        #3 reset_n = 1'b1;

        set_slot(0, 1'b1, 100, 50);
        step(100, 50);
        check("pre_shadow_hit", 32'(pix_if.hit), 32'd0);
        step(639, 479);
        check("tick_high", 32'(pix_if.frame_tick), 32'd1);
        step(0, 0);
        check("tick_low", 32'(pix_if.frame_tick), 32'd0);
        step(100, 50);
        check_pix("s0_origin", 1'b1, 0, 0);
        step(150, 60);
        check_pix("s0_mid", 1'b1, 0, 690);

        #3 reset_n = 1'b0;
        #1;
        check_pix("async_rst", 1'b0, 0, 0);
        #2 reset_n = 1'b1;
        step(100, 50);
        check("post_rst_no_hit", 32'(pix_if.hit), 32'd0);
        frame();
        step(100, 50);
        check_pix("s0_again", 1'b1, 0, 0);
        step(163, 113);
        check_pix("s0_corner", 1'b1, 0, 4095);
        step(164, 50);
        check_pix("s0_right_out", 1'b0, 0, 0);
        step(100, 114);
        check("s0_below_out", 32'(pix_if.hit), 32'd0);

        set_slot(1, 1'b1, 200, 200);
        set_slot(2, 1'b1, 200, 200);
        frame();
        step(210, 205);
        check_pix("prio_s1", 1'b1, 1, 330);
        slot_en[1] = 1'b0;
        step(210, 205);
        check_pix("shadow_hold", 1'b1, 1, 330);
        frame();
        step(210, 205);
        check_pix("prio_s2", 1'b1, 2, 330);

        anim_run = 1'b1;
        repeat (7) frame();
        check("anim_7", 32'(pix_if.frame_idx), 32'd0);
        frame();
        check("anim_8", 32'(pix_if.frame_idx), 32'd1);
        repeat (8) frame();
        check("anim_16", 32'(pix_if.frame_idx), 32'd2);
        step(100, 50);
        check_pix("addr_f2", 1'b1, 0, 8192);
        repeat (15) frame();
        check("anim_31", 32'(pix_if.frame_idx), 32'd3);
        frame();
        check("anim_32_wrap", 32'(pix_if.frame_idx), 32'd0);
        repeat (16) frame();
        check("anim_48", 32'(pix_if.frame_idx), 32'd2);

        anim_run = 1'b0;
        step(0, 0);
        repeat (20) frame();
        check("pause_hold", 32'(pix_if.frame_idx), 32'd2);
        anim_restart = 1'b1;
        step(300, 300);
        anim_restart = 1'b0;
        check("restart_defer", 32'(pix_if.frame_idx), 32'd2);
        step(639, 479);
        check("restart_at_tick_pre", 32'(pix_if.frame_idx), 32'd2);
        step(0, 0);
        check("restart_applied", 32'(pix_if.frame_idx), 32'd0);

        anim_run = 1'b1;
        step(0, 0);
        repeat (7) frame();
        check("rs_div7", 32'(pix_if.frame_idx), 32'd0);
        step(639, 479);
        anim_restart = 1'b1;
        step(0, 0);
        anim_restart = 1'b0;
        check("restart_beats_step", 32'(pix_if.frame_idx), 32'd0);
        repeat (7) frame();
        check("div_cleared", 32'(pix_if.frame_idx), 32'd0);
        frame();
        check("div_cleared_step", 32'(pix_if.frame_idx), 32'd1);

        anim_run = 1'b0;
        step(0, 0);
        slot_en = 4'b0000;
        set_slot(3, 1'b1, 600, 400);
        frame();
        step(600, 400);
        check_pix("clip_left", 1'b1, 3, 4096);
        step(639, 400);
        check_pix("clip_right", 1'b1, 3, 4135);
        step(0, 400);
        check("no_wrap", 32'(pix_if.hit), 32'd0);
        pix_if.blank = 1'b0;
        step(610, 400);
        check("blanked", 32'(pix_if.hit), 32'd0);
        pix_if.blank = 1'b1;
        step(620, 463);
        check_pix("clip_bottom", 1'b1, 3, 8148);
        step(620, 464);
        check("below_bottom", 32'(pix_if.hit), 32'd0);

`ifdef DUCK_SPRITE_MIRROR_EN
        slot_flip[3] = 1'b1;
        frame();
        step(600, 400);
        check_pix("mirror_left", 1'b1, 3, 4159);
        step(639, 400);
        check_pix("mirror_right", 1'b1, 3, 4120);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
